// File: rtl/tpu_pkg.sv
// Shared types and constants for the systolic matrix-multiply controller.
// Address defaults assume a 16-bit bus; the top resizes them to ADDRW.
package tpu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic a;
      logic b;
      logic c;
      logic cmd;
      logic stat;
   } region_t;

   localparam logic [15:0] DEF_A_BASE    = 16'h0100;
   localparam logic [15:0] DEF_B_BASE    = 16'h0200;
   localparam logic [15:0] DEF_C_BASE    = 16'h0300;
   localparam logic [15:0] DEF_CMD_ADDR  = 16'h0400;
   localparam logic [15:0] DEF_STAT_ADDR = 16'h0408;

   localparam int STAT_BUSY = 0;
   localparam int STAT_DONE = 1;
   localparam int STAT_ERR  = 2;

   localparam int CMD_START = 0;
   localparam int CMD_ACC   = 1;

   // Index width that never collapses to zero bits for degenerate sizes.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tpu_addr_dec.sv
// Combinational host address decoder: one-hot region hit plus the word
// index inside the hit region (sub-word byte bits are dropped).
import tpu_pkg::*;

module tpu_addr_dec #(
   parameter int               ADDRW     = 16,
   parameter int               DATAW     = 64,
   parameter int               DIM       = 8,
   parameter int               NWC       = 2,
   parameter logic [ADDRW-1:0] A_BASE    = ADDRW'(DEF_A_BASE),
   parameter logic [ADDRW-1:0] B_BASE    = ADDRW'(DEF_B_BASE),
   parameter logic [ADDRW-1:0] C_BASE    = ADDRW'(DEF_C_BASE),
   parameter logic [ADDRW-1:0] CMD_ADDR  = ADDRW'(DEF_CMD_ADDR),
   parameter logic [ADDRW-1:0] STAT_ADDR = ADDRW'(DEF_STAT_ADDR)
) (
   input  logic [ADDRW-1:0] addr,
   output region_t          region,
   output logic [ADDRW-1:0] idx
);

   localparam int              SHIFT   = $clog2(DATAW / 8);
   localparam logic [ADDRW:0]  AB_SPAN = (ADDRW+1)'(DIM << SHIFT);
   localparam logic [ADDRW:0]  C_SPAN  = (ADDRW+1)'((DIM * NWC) << SHIFT);

   logic [ADDRW-1:0] off_a, off_b, off_c;

   always_comb begin
      // NOTE: every output gets a default before any branch, so no path can leave one unassigned and infer a latch.
      region = '0;
      idx    = '0;
      off_a  = addr - A_BASE;
      off_b  = addr - B_BASE;
      off_c  = addr - C_BASE;

      region.a    = (addr >= A_BASE) && ({1'b0, off_a} < AB_SPAN);
      region.b    = (addr >= B_BASE) && ({1'b0, off_b} < AB_SPAN);
      region.c    = (addr >= C_BASE) && ({1'b0, off_c} < C_SPAN);
      region.cmd  = (addr == CMD_ADDR);
      region.stat = (addr == STAT_ADDR);

      if (region.a)      idx = off_a >> SHIFT;
      else if (region.b) idx = off_b >> SHIFT;
      else if (region.c) idx = off_c >> SHIFT;
   end

endmodule

// File: rtl/tpu_ctrl.sv
// Memory-mapped controller for the systolic matmul datapath: decodes host
// accesses into A/B/C strobes and sequences clear/accumulate multiply runs.
import tpu_pkg::*;

module tpu_ctrl #(
   parameter int               BITS_AB   = 8,
   parameter int               BITS_C    = 16,
   parameter int               DIM       = 8,
   parameter int               ADDRW     = 16,
   parameter int               DATAW     = 64,
   parameter logic [ADDRW-1:0] A_BASE    = ADDRW'(DEF_A_BASE),
   parameter logic [ADDRW-1:0] B_BASE    = ADDRW'(DEF_B_BASE),
   parameter logic [ADDRW-1:0] C_BASE    = ADDRW'(DEF_C_BASE),
   parameter logic [ADDRW-1:0] CMD_ADDR  = ADDRW'(DEF_CMD_ADDR),
   parameter logic [ADDRW-1:0] STAT_ADDR = ADDRW'(DEF_STAT_ADDR)
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic                                      valid,
   input  logic                                      r_w,
   input  logic [ADDRW-1:0]                          addr,
   input  logic [DATAW-1:0]                          dataIn,
   output logic [DATAW-1:0]                          dataOut,
   output logic                                      rd_valid,
   output logic                                      irq,
   output logic                                      a_wr_en,
   output logic [clog2_min1(DIM)-1:0]                a_row,
   output logic                                      b_en,
   output logic                                      c_wr_en,
   output logic [clog2_min1(DIM)-1:0]                c_row,
   output logic [clog2_min1(DIM*BITS_C/DATAW)-1:0]   c_word,
   input  logic [DIM*BITS_C-1:0]                     c_rd_data,
   output logic                                      sys_en,
   output logic                                      sys_clr
);

   localparam int              NWC      = DIM * BITS_C / DATAW;
   localparam int              RW       = clog2_min1(DIM);
   localparam int              CWW      = clog2_min1(NWC);
   localparam int              CNTW     = clog2_min1(3 * DIM - 2);
   localparam logic [CNTW-1:0] RUN_LAST = CNTW'(3 * DIM - 3);
   localparam logic [31:0]     ROW_BITS = 32'(DIM * BITS_AB);

   region_t          region;
   logic [ADDRW-1:0] idx;

   tpu_addr_dec #(
      .ADDRW    (ADDRW),
      .DATAW    (DATAW),
      .DIM      (DIM),
      .NWC      (NWC),
      .A_BASE   (A_BASE),
      .B_BASE   (B_BASE),
      .C_BASE   (C_BASE),
      .CMD_ADDR (CMD_ADDR),
      .STAT_ADDR(STAT_ADDR)
   ) u_dec (
      .addr  (addr),
      .region(region),
      .idx   (idx)
   );

   state_t           state, state_nxt;
   logic [CNTW-1:0]  cnt;
   logic             done, err;
   logic             idle, busy, wr, rd, mapped, start, stat_rd, err_set, c_sel;
   logic [DATAW-1:0] rd_data;

   // A/B row payloads travel on dataIn straight to the datapath; only the
   // command bits are interpreted here.
   logic unused_bits;
   assign unused_bits = ^{dataIn[DATAW-1:2], ROW_BITS};

   assign idle    = (state == IDLE);
   assign busy    = (state == CLEAR) || (state == RUN);
   assign wr      = valid && r_w;
   assign rd      = valid && !r_w;
   assign mapped  = region.a || region.b || region.c || region.cmd || region.stat;
   assign start   = idle && wr && region.cmd && dataIn[CMD_START];
   assign stat_rd = rd && region.stat;
   assign err_set = !idle && ((wr && mapped) || (rd && region.c));
   assign c_sel   = idle && valid && region.c;

   always_comb begin
      a_wr_en = idle && wr && region.a;
      b_en    = idle && wr && region.b;
      c_wr_en = idle && wr && region.c;
      a_row   = a_wr_en ? idx[RW-1:0] : '0;
      c_row   = c_sel ? RW'(idx / NWC) : '0;
      c_word  = c_sel ? CWW'(idx % NWC) : '0;
      sys_clr = (state == CLEAR);
      sys_en  = (state == RUN);
      irq     = (state == DONE);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = dataIn[CMD_ACC] ? RUN : CLEAR;
         CLEAR:   state_nxt = RUN;
         RUN:     if (cnt == RUN_LAST) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // C reads while a run is in flight return zero; c_word is only non-zero for an idle C access.
   always_comb begin
      rd_data = '0;
      if (region.stat) begin
         rd_data[STAT_BUSY] = busy;
         rd_data[STAT_DONE] = done;
         rd_data[STAT_ERR]  = err;
      end else if (region.c && idle) begin
         rd_data = c_rd_data[c_word*DATAW +: DATAW];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
         rd_valid <= 1'b0;
         dataOut  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop sees the pre-edge values of the others.
         state <= state_nxt;
         cnt   <= (state == RUN && cnt != RUN_LAST) ? cnt + CNTW'(1) : '0;

         // Completion outranks a same-cycle status read so the flag is not lost.
         if (start)               done <= 1'b0;
         else if (state == DONE)  done <= 1'b1;
         else if (stat_rd)        done <= 1'b0;

         if (err_set)             err <= 1'b1;
         else if (stat_rd)        err <= 1'b0;

         rd_valid <= rd;
         if (rd) dataOut <= rd_data;
      end
   end

endmodule

// File: tb/tb_tpu_ctrl.sv
// Directed bench for tpu_ctrl at default parameters (DIM=8, DATAW=64, NWC=2).
module tb_tpu_ctrl;

   localparam logic [15:0] CMD  = 16'h0400;
   localparam logic [15:0] STAT = 16'h0408;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         valid = 1'b0;
   logic         r_w = 1'b0;
   logic [15:0]  addr = '0;
   logic [63:0]  dataIn = '0;
   logic [63:0]  dataOut;
   logic         rd_valid, irq, a_wr_en, b_en, c_wr_en, sys_en, sys_clr;
   logic [2:0]   a_row, c_row;
   logic [0:0]   c_word;
   logic [127:0] c_rd_data;

   int total = 0;
   int bad   = 0;

   // Array model: word 0 of row r = A1..0r, word 1 = B1..0r.
   assign c_rd_data = {8'hB1, 53'h0, c_row, 8'hA1, 53'h0, c_row};

   always #5 clk = ~clk;

   tpu_ctrl dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .valid    (valid),
      .r_w      (r_w),
      .addr     (addr),
      .dataIn   (dataIn),
      .dataOut  (dataOut),
      .rd_valid (rd_valid),
      .irq      (irq),
      .a_wr_en  (a_wr_en),
      .a_row    (a_row),
      .b_en     (b_en),
      .c_wr_en  (c_wr_en),
      .c_row    (c_row),
      .c_word   (c_word),
      .c_rd_data(c_rd_data),
      .sys_en   (sys_en),
      .sys_clr  (sys_clr)
   );

   task automatic drive_req(input logic rw, input logic [15:0] a, input logic [63:0] d);
      @(negedge clk);
      valid = 1'b1; r_w = rw; addr = a; dataIn = d;
      #1;
   endtask

   task automatic release_bus();
      @(posedge clk);
      #1;
      valid = 1'b0; r_w = 1'b0; addr = '0; dataIn = '0;
   endtask

   task automatic read_word(input logic [15:0] a, output logic [63:0] d, output logic v);
      drive_req(1'b0, a, '0);
      release_bus();
      @(negedge clk);
      d = dataOut; v = rd_valid;
   endtask

   task automatic run_start(input logic [63:0] cmd, input int stat_at,
                            output int clr_n, output int en_n, output int en_first,
                            output int en_last, output int irq_n, output int irq_at,
                            output logic [63:0] stat_val, output logic stat_vld);
      clr_n = 0; en_n = 0; en_first = -1; en_last = -1; irq_n = 0; irq_at = -1;
      stat_val = 'x; stat_vld = 1'b0;
      drive_req(1'b1, CMD, cmd);
      for (int k = 1; k <= 32; k++) begin
         @(negedge clk);
         valid = 1'b0; r_w = 1'b0; addr = '0; dataIn = '0;
         if (k == stat_at + 1) begin stat_val = dataOut; stat_vld = rd_valid; end
         if (sys_clr) clr_n++;
         if (sys_en) begin
            if (en_first < 0) en_first = k;
            en_last = k;
            en_n++;
         end
         if (irq) begin
            if (irq_at < 0) irq_at = k;
            irq_n++;
         end
         if (k == stat_at) begin valid = 1'b1; addr = STAT; end
      end
   endtask

   task automatic test_reset();
      logic [63:0] d; logic v;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({dataOut, rd_valid, irq, a_wr_en, a_row, b_en, c_wr_en, c_row, c_word, sys_en, sys_clr} !== '0) begin
         bad++; $display("FAIL reset_hold: outputs not all zero, dataOut=%h rd_valid=%b", dataOut, rd_valid);
      end
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      total++;
      if ({dataOut, rd_valid, irq, a_wr_en, a_row, b_en, c_wr_en, c_row, c_word, sys_en, sys_clr} !== '0) begin
         bad++; $display("FAIL reset_idle: outputs not all zero, irq=%b sys_en=%b", irq, sys_en);
      end
      read_word(STAT, d, v);
      total++;
      if (v !== 1'b1 || d !== 64'h0) begin
         bad++; $display("FAIL reset_stat: rd_valid=%b data=%h want 1/0", v, d);
      end
      @(negedge clk);
      total++;
      if (rd_valid !== 1'b0) begin
         bad++; $display("FAIL rd_valid_pulse: rd_valid=%b want 0", rd_valid);
      end
   endtask

   task automatic test_writes();
      logic [63:0] d; logic v;
      for (int i = 0; i < 8; i++) begin
         drive_req(1'b1, 16'h0100 + 16'(8 * i), 64'(i));
         total++;
         if (a_wr_en !== 1'b1 || a_row !== 3'(i) || b_en !== 1'b0 || c_wr_en !== 1'b0) begin
            bad++; $display("FAIL a_write[%0d]: a_wr_en=%b a_row=%0d want 1/%0d", i, a_wr_en, a_row, i);
         end
         release_bus();
      end
      drive_req(1'b1, 16'h0105, 64'h0);
      total++;
      if (a_wr_en !== 1'b1 || a_row !== 3'd0) begin
         bad++; $display("FAIL a_low_bits: a_wr_en=%b a_row=%0d want 1/0", a_wr_en, a_row);
      end
      release_bus();
      drive_req(1'b1, 16'h0238, 64'h0);
      total++;
      if (b_en !== 1'b1 || a_wr_en !== 1'b0) begin
         bad++; $display("FAIL b_write: b_en=%b a_wr_en=%b want 1/0", b_en, a_wr_en);
      end
      release_bus();
      drive_req(1'b1, 16'h0140, 64'h0);
      total++;
      if ({a_wr_en, b_en, c_wr_en} !== 3'b000) begin
         bad++; $display("FAIL a_past_end: strobes=%b want 000", {a_wr_en, b_en, c_wr_en});
      end
      release_bus();
      drive_req(1'b1, 16'h0318, 64'h0);
      total++;
      if (c_wr_en !== 1'b1 || c_row !== 3'd1 || c_word !== 1'b1) begin
         bad++; $display("FAIL c_write: c_wr_en=%b row=%0d word=%0d want 1/1/1", c_wr_en, c_row, c_word);
      end
      release_bus();
      drive_req(1'b1, 16'h0378, 64'h0);
      total++;
      if (c_wr_en !== 1'b1 || c_row !== 3'd7 || c_word !== 1'b1) begin
         bad++; $display("FAIL c_last: c_wr_en=%b row=%0d word=%0d want 1/7/1", c_wr_en, c_row, c_word);
      end
      release_bus();
      drive_req(1'b1, 16'h0380, 64'h0);
      total++;
      if (c_wr_en !== 1'b0) begin
         bad++; $display("FAIL c_past_end: c_wr_en=%b want 0", c_wr_en);
      end
      release_bus();
      drive_req(1'b1, 16'h0500, 64'hFF);
      release_bus();
      drive_req(1'b1, CMD, 64'h2);
      release_bus();
      repeat (2) @(negedge clk);
      total++;
      if ({sys_clr, sys_en, irq} !== 3'b000) begin
         bad++; $display("FAIL start_bit0_zero: clr/en/irq=%b want 000", {sys_clr, sys_en, irq});
      end
      read_word(STAT, d, v);
      total++;
      if (v !== 1'b1 || d !== 64'h0) begin
         bad++; $display("FAIL unmapped_no_err: rd_valid=%b stat=%h want 1/0", v, d);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      valid = 1'b1; r_w = 1'b0; addr = 16'h0300;
      @(negedge clk);
      total++;
      if (rd_valid !== 1'b1 || dataOut !== 64'hA100_0000_0000_0000) begin
         bad++; $display("FAIL c_read_w0: rd_valid=%b data=%h want 1/a100000000000000", rd_valid, dataOut);
      end
      addr = 16'h0318;
      @(negedge clk);
      total++;
      if (rd_valid !== 1'b1 || dataOut !== 64'hB100_0000_0000_0001) begin
         bad++; $display("FAIL c_read_b2b: rd_valid=%b data=%h want 1/b100000000000001", rd_valid, dataOut);
      end
      addr = 16'h0370;
      @(negedge clk);
      total++;
      if (rd_valid !== 1'b1 || dataOut !== 64'hA100_0000_0000_0007) begin
         bad++; $display("FAIL c_read_row7: rd_valid=%b data=%h want 1/a100000000000007", rd_valid, dataOut);
      end
      addr = 16'h0108;
      @(negedge clk);
      total++;
      if (rd_valid !== 1'b1 || dataOut !== 64'h0) begin
         bad++; $display("FAIL a_read_zero: rd_valid=%b data=%h want 1/0", rd_valid, dataOut);
      end
      addr = 16'h0318;
      @(negedge clk);
      valid = 1'b0; addr = '0;
      @(negedge clk);
      total++;
      if (rd_valid !== 1'b0 || dataOut !== 64'hB100_0000_0000_0001) begin
         bad++; $display("FAIL read_hold: rd_valid=%b data=%h want 0/b100000000000001", rd_valid, dataOut);
      end
   endtask

   task automatic test_clear_run();
      int clr_n, en_n, en_first, en_last, irq_n, irq_at;
      logic [63:0] sv, d; logic svld, v;
      run_start(64'h1, 5, clr_n, en_n, en_first, en_last, irq_n, irq_at, sv, svld);
      total++;
      if (clr_n != 1 || en_first != 2 || en_last != 23 || en_n != 22) begin
         bad++; $display("FAIL clear_seq: clr=%0d en_first=%0d en_last=%0d en_n=%0d want 1/2/23/22", clr_n, en_first, en_last, en_n);
      end
      total++;
      if (irq_at != 24 || irq_n != 1) begin
         bad++; $display("FAIL clear_irq: irq_at=%0d irq_n=%0d want 24/1", irq_at, irq_n);
      end
      total++;
      if (svld !== 1'b1 || sv !== 64'h1) begin
         bad++; $display("FAIL stat_busy: rd_valid=%b stat=%h want 1/1", svld, sv);
      end
      read_word(STAT, d, v);
      total++;
      if (d !== 64'h2) begin
         bad++; $display("FAIL stat_done: stat=%h want 2", d);
      end
      read_word(STAT, d, v);
      total++;
      if (d !== 64'h0) begin
         bad++; $display("FAIL stat_done_clr: stat=%h want 0", d);
      end
   endtask

   task automatic test_acc_run();
      int clr_n, en_n, en_first, en_last, irq_n, irq_at;
      logic [63:0] sv, d; logic v, svld;
      run_start(64'h3, 23, clr_n, en_n, en_first, en_last, irq_n, irq_at, sv, svld);
      total++;
      if (clr_n != 0 || en_first != 1 || en_last != 22 || en_n != 22) begin
         bad++; $display("FAIL acc_seq: clr=%0d en_first=%0d en_last=%0d en_n=%0d want 0/1/22/22", clr_n, en_first, en_last, en_n);
      end
      total++;
      if (irq_at != 23 || irq_n != 1) begin
         bad++; $display("FAIL acc_irq: irq_at=%0d irq_n=%0d want 23/1", irq_at, irq_n);
      end
      total++;
      if (svld !== 1'b1 || sv !== 64'h0) begin
         bad++; $display("FAIL stat_in_done: rd_valid=%b stat=%h want 1/0", svld, sv);
      end
      read_word(STAT, d, v);
      total++;
      if (d !== 64'h2) begin
         bad++; $display("FAIL done_kept: stat=%h want 2", d);
      end
      read_word(STAT, d, v);
   endtask

   task automatic test_mid_run_err();
      logic [63:0] d; logic v; logic got;
      read_word(16'h0318, d, v);
      drive_req(1'b1, CMD, 64'h1);
      release_bus();
      repeat (3) @(negedge clk);
      drive_req(1'b1, 16'h0100, 64'hFF);
      total++;
      if (a_wr_en !== 1'b0) begin
         bad++; $display("FAIL busy_a_write: a_wr_en=%b want 0", a_wr_en);
      end
      release_bus();
      read_word(16'h0300, d, v);
      total++;
      if (v !== 1'b1 || d !== 64'h0) begin
         bad++; $display("FAIL busy_c_read: rd_valid=%b data=%h want 1/0", v, d);
      end
      drive_req(1'b1, CMD, 64'h1);
      release_bus();
      got = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (irq) begin got = 1'b1; break; end
      end
      total++;
      if (got !== 1'b1) begin
         bad++; $display("FAIL busy_irq_timeout: irq seen=%b want 1", got);
      end
      read_word(STAT, d, v);
      total++;
      if (d !== 64'h6) begin
         bad++; $display("FAIL err_flag: stat=%h want 6", d);
      end
      read_word(STAT, d, v);
      total++;
      if (d !== 64'h0) begin
         bad++; $display("FAIL err_cleared: stat=%h want 0", d);
      end
   endtask

   task automatic test_reset_mid_run();
      logic [63:0] d, sv; logic v, svld, seen;
      int clr_n, en_n, en_first, en_last, irq_n, irq_at;
      read_word(16'h0318, d, v);
      drive_req(1'b1, CMD, 64'h1);
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         valid = 1'b0; r_w = 1'b0; addr = '0; dataIn = '0;
      end
      total++;
      if (sys_en !== 1'b1) begin
         bad++; $display("FAIL run_before_reset: sys_en=%b want 1", sys_en);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if ({dataOut, rd_valid, irq, a_wr_en, a_row, b_en, c_wr_en, c_row, c_word, sys_en, sys_clr} !== '0) begin
         bad++; $display("FAIL reset_abort: dataOut=%h sys_en=%b irq=%b want 0", dataOut, sys_en, irq);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (irq || sys_en) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin
         bad++; $display("FAIL reset_no_irq: activity=%b want 0", seen);
      end
      run_start(64'h1, 30, clr_n, en_n, en_first, en_last, irq_n, irq_at, sv, svld);
      total++;
      if (clr_n != 1 || en_n != 22 || en_first != 2 || irq_at != 24 || irq_n != 1) begin
         bad++; $display("FAIL restart: clr=%0d en_n=%0d en_first=%0d irq_at=%0d want 1/22/2/24", clr_n, en_n, en_first, irq_at);
      end
   endtask

   initial begin
      test_reset();
      test_writes();
      test_back_to_back();
      test_clear_run();
      test_acc_run();
      test_mid_run_err();
      test_reset_mid_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
